// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage CowCat32 pipeline.
// It resolves load-use hazards, EX redirects, multi-cycle MDU ops and
// data-memory wait states. Hold and flush outputs are combinational, so
// the pipeline registers act on the same edge.
// Optional build macro: HAZARD_STATS_EN adds the stall/flush statistics
// counters. Without it, both counter outputs are tied to zero.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             ex_mem_hold,
  output logic             mem_wb_hold,
  output logic             if_id_flush_n,
  output logic             id_ex_flush_n,
  output logic             ex_mem_flush_n,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  localparam logic [7:0] TMO_MAX  = 8'(MEM_TIMEOUT);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nx;
  logic       done_pending, done_pending_nx;
  logic [7:0] wait_cnt;
  logic       freeze, mdu_stall, load_use;

  // FSM state and the latched MDU completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      done_pending <= 1'b0;
    end else begin
      state        <= state_nx;
      done_pending <= done_pending_nx;
    end
  end

  // Hazard detection, next-state logic and priority-encoded hold/flush outputs.
  always_comb begin
    state_nx        = state;
    done_pending_nx = done_pending;
    pc_hold         = 1'b0;
    if_id_hold      = 1'b0;
    id_ex_hold      = 1'b0;
    ex_mem_hold     = 1'b0;
    mem_wb_hold     = 1'b0;
    if_id_flush_n   = 1'b1;
    id_ex_flush_n   = 1'b1;
    ex_mem_flush_n  = 1'b1;

    freeze    = mem_busy;
    mdu_stall = ((state == RUN) && ex_mdu_start && !mdu_done) ||
                ((state == MDU_WAIT) && !mdu_done && !done_pending);
    load_use  = ex_is_load && (ex_rd != 5'd0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));

    // A completion that lands while memory freezes the pipe is remembered
    // so the wait can end on the first unfrozen cycle.
    if (state == MDU_WAIT && mdu_done && freeze)
      done_pending_nx = 1'b1;

    if (!freeze) begin
      if (state == RUN && ex_mdu_start && !mdu_done) begin
        state_nx = MDU_WAIT;
      end else if (state == MDU_WAIT && (mdu_done || done_pending)) begin
        state_nx        = RUN;
        done_pending_nx = 1'b0;
      end
    end

    if (rst) begin
      if (freeze) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        mem_wb_hold = 1'b1;
      end else if (mdu_stall) begin
        pc_hold        = 1'b1;
        if_id_hold     = 1'b1;
        id_ex_hold     = 1'b1;
        ex_mem_flush_n = 1'b0;
      end else if (ex_redirect) begin
        if_id_flush_n = 1'b0;
        id_ex_flush_n = 1'b0;
      end else if (load_use) begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_flush_n = 1'b0;
      end
    end
  end

  // Consecutive memory-wait counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (mem_busy) begin
        if (wait_cnt != TMO_MAX)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == TMO_LAST)
          mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic any_flush;
  assign any_flush = ~(if_id_flush_n & id_ex_flush_n & ex_mem_flush_n);

  // Statistics counters: stalled cycles and cycles carrying a flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_hold)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (any_flush)
        flush_events <= flush_events + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table, hand-written
// multi-cycle sequences and randomized traffic checked against a model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MT = 4;
  localparam int unsigned CW = 32;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, ex_mdu_start, mdu_done, mem_busy;
  logic pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold;
  logic if_id_flush_n, id_ex_flush_n, ex_mem_flush_n, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
    .ex_mem_hold(ex_mem_hold), .mem_wb_hold(mem_wb_hold),
    .if_id_flush_n(if_id_flush_n), .id_ex_flush_n(id_ex_flush_n),
    .ex_mem_flush_n(ex_mem_flush_n), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, ld, redir, start, done, busy;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [7:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: an outstanding-MDU flag, a remembered completion,
  // a plain run-length of busy cycles and the counters.
  bit          m_out, m_seen, m_tmo;
  int          m_run;
  logic [31:0] m_sc, m_fe;

  vec_t tbl[12];

  function automatic in_t mk(int rs1, int rs2, int u1, int u2, int rd,
                             int ld, int redir, int start, int done, int busy);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = (u1 != 0); v.u2 = (u2 != 0); v.ld = (ld != 0);
    v.redir = (redir != 0); v.start = (start != 0);
    v.done = (done != 0); v.busy = (busy != 0);
    return v;
  endfunction

  // {pc, if_id_h, id_ex_h, ex_mem_h, mem_wb_h, if_id_fn, id_ex_fn, ex_mem_fn}
  function automatic logic [7:0] dut_out();
    return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold,
            if_id_flush_n, id_ex_flush_n, ex_mem_flush_n};
  endfunction

  function automatic bit m_stall(in_t v);
    return (!m_out && v.start && !v.done) || (m_out && !v.done && !m_seen);
  endfunction

  function automatic logic [7:0] m_expect(in_t v, bit r);
    bit lu;
    lu = v.ld && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (!r)              return 8'b00000_111;
    else if (v.busy)     return 8'b11111_111;
    else if (m_stall(v)) return 8'b11100_110;
    else if (v.redir)    return 8'b00000_001;
    else if (lu)         return 8'b11000_101;
    else                 return 8'b00000_111;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(input in_t v, input bit r, input logic [7:0] o);
    if (!r) begin
      m_out = 0; m_seen = 0; m_tmo = 0; m_run = 0; m_sc = '0; m_fe = '0;
    end else begin
      if (STATS) begin
        if (o[7]) m_sc = m_sc + 32'd1;
        if (o[2:0] != 3'b111) m_fe = m_fe + 32'd1;
      end
      if (v.busy) begin
        if (m_out && v.done) m_seen = 1;
      end else if (!m_out && v.start && !v.done) begin
        m_out = 1;
      end else if (m_out && (v.done || m_seen)) begin
        m_out = 0; m_seen = 0;
      end
      m_run = v.busy ? m_run + 1 : 0;
      if (m_run >= int'(MT)) m_tmo = 1;
    end
  endtask

  task automatic step(input in_t v, input bit r, input bit use_want,
                      input logic [7:0] want, input string name);
    logic [7:0] mexp;
    rst = r;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_redirect = v.redir;
    ex_mdu_start = v.start; mdu_done = v.done; mem_busy = v.busy;
    @(negedge clk);
    mexp = m_expect(v, r);
    assert (!(r && v.redir && m_stall(v)))
      else $error("stimulus drove ex_redirect during an MDU stall");
    chk(name, 32'(dut_out()), 32'(use_want ? want : mexp));
    chk({name, "_tmo"}, 32'(mem_timeout), 32'(m_tmo));
    chk({name, "_sc"}, 32'(stall_cycles), m_sc);
    chk({name, "_fe"}, 32'(flush_events), m_fe);
    model_update(v, r, mexp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle, lu, st, dn, by, v;
    int burst;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    st   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    dn   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    by   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = '{name: "idle",       v: idle,                               exp: 8'b00000_111};
    tbl[1]  = '{name: "lu_rs1",     v: lu,                                 exp: 8'b11000_101};
    tbl[2]  = '{name: "lu_rs2",     v: mk(3, 5, 1, 1, 5, 1, 0, 0, 0, 0),   exp: 8'b11000_101};
    tbl[3]  = '{name: "rd_zero",    v: mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0),   exp: 8'b00000_111};
    tbl[4]  = '{name: "rs_unused",  v: mk(5, 5, 0, 0, 5, 1, 0, 0, 0, 0),   exp: 8'b00000_111};
    tbl[5]  = '{name: "not_load",   v: mk(5, 5, 1, 1, 5, 0, 0, 0, 0, 0),   exp: 8'b00000_111};
    tbl[6]  = '{name: "redir",      v: mk(1, 2, 1, 1, 9, 0, 1, 0, 0, 0),   exp: 8'b00000_001};
    tbl[7]  = '{name: "redir_lu",   v: mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 0),   exp: 8'b00000_001};
    tbl[8]  = '{name: "busy_all",   v: mk(5, 0, 1, 0, 5, 1, 1, 0, 0, 1),   exp: 8'b11111_111};
    tbl[9]  = '{name: "start_done", v: mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),   exp: 8'b00000_111};
    tbl[10] = '{name: "lu_both",    v: mk(6, 7, 1, 1, 7, 1, 0, 0, 0, 0),   exp: 8'b11000_101};
    tbl[11] = '{name: "rs2_unused", v: mk(4, 7, 1, 0, 7, 1, 0, 0, 0, 0),   exp: 8'b00000_111};

    // Unchecked power-on reset, then a checked reset cycle with a live hazard.
    rst = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0; ex_is_load = 0; ex_redirect = 0;
    ex_mdu_start = 0; mdu_done = 0; mem_busy = 0;
    m_out = 0; m_seen = 0; m_tmo = 0; m_run = 0; m_sc = '0; m_fe = '0;
    repeat (2) @(posedge clk);
    #1;
    step(lu, 1'b0, 1'b1, 8'b00000_111, "reset_out");

    // Single-cycle vectors from RUN.
    for (int i = 0; i < 12; i++)
      step(tbl[i].v, 1'b1, 1'b1, tbl[i].exp, tbl[i].name);

    // Load-use lasts one cycle: the bubble removes the load from EX.
    step(lu,   1'b1, 1'b1, 8'b11000_101, "lu_once");
    step(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 8'b00000_111, "lu_after");

    // MDU op with completion four cycles after the start pulse.
    step(idle, 1'b0, 1'b1, 8'b00000_111, "mdu_rst");
    step(st,   1'b1, 1'b1, 8'b11100_110, "mdu_c0");
    for (int i = 1; i < 4; i++)
      step(idle, 1'b1, 1'b1, 8'b11100_110, "mdu_wait");
    step(dn,   1'b1, 1'b1, 8'b00000_111, "mdu_done");
    step(idle, 1'b1, 1'b1, 8'b00000_111, "mdu_run");
    chk("mdu_stall_cnt", stall_cycles, STATS ? 32'd4 : 32'd0);
    chk("mdu_flush_cnt", flush_events, STATS ? 32'd4 : 32'd0);

    // Completion hidden inside a three-cycle memory freeze.
    step(idle, 1'b0, 1'b1, 8'b00000_111, "dp_rst");
    step(st,   1'b1, 1'b1, 8'b11100_110, "dp_start");
    step(by,   1'b1, 1'b1, 8'b11111_111, "dp_busy0");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1, 1'b1, 8'b11111_111, "dp_busy_done");
    step(by,   1'b1, 1'b1, 8'b11111_111, "dp_busy2");
    step(idle, 1'b1, 1'b1, 8'b00000_111, "dp_release");
    step(idle, 1'b1, 1'b1, 8'b00000_111, "dp_run");
    step(lu,   1'b1, 1'b1, 8'b11000_101, "dp_run_lu");

    // Memory timeout at MEM_TIMEOUT consecutive busy cycles, sticky until reset.
    step(idle, 1'b0, 1'b1, 8'b00000_111, "tmo_rst");
    for (int i = 0; i < 3; i++)
      step(by, 1'b1, 1'b1, 8'b11111_111, "tmo_busy");
    chk("tmo_early", 32'(mem_timeout), 32'd0);
    step(by,   1'b1, 1'b1, 8'b11111_111, "tmo_busy3");
    chk("tmo_set", 32'(mem_timeout), 32'd1);
    step(idle, 1'b1, 1'b1, 8'b00000_111, "tmo_idle0");
    step(idle, 1'b1, 1'b1, 8'b00000_111, "tmo_idle1");
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);
    step(idle, 1'b0, 1'b1, 8'b00000_111, "tmo_rst2");
    chk("tmo_clr", 32'(mem_timeout), 32'd0);

    // Reset while waiting on the MDU leaves no stall behind.
    step(st,   1'b1, 1'b1, 8'b11100_110, "mrst_start");
    step(idle, 1'b1, 1'b1, 8'b11100_110, "mrst_wait");
    step(idle, 1'b0, 1'b1, 8'b00000_111, "mrst_rst");
    step(idle, 1'b1, 1'b1, 8'b00000_111, "mrst_after");

    // Randomized traffic against the model.
    burst = 0;
    for (int n = 0; n < 600; n++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), 0,
             (!m_out && $urandom_range(0, 5) == 0) ? 1 : 0,
             (m_out && $urandom_range(0, 3) == 0) ? 1 : 0, 0);
      if (burst > 0) begin
        v.busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        burst = $urandom_range(0, 6);
        v.busy = 1'b1;
      end
      if (!m_stall(v) && $urandom_range(0, 5) == 0)
        v.redir = 1'b1;
      step(v, ($urandom_range(0, 149) != 0), 1'b0, 8'h00, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage CowCat32 pipeline (IF, ID, EX, MEM, WB).
- Drives the hold and active-low flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC hold.
- Resolves load-use hazards, EX-stage redirects, multi-cycle MDU ops and data-memory wait states.
- Stall/flush outputs are combinational from current inputs and state, so the registers act on the same edge (0-cycle latency).

Parameters:
- MEM_TIMEOUT, 64: consecutive mem_busy cycles before mem_timeout is raised (legal range 2..255).
- CNT_W, 32: width of the optional statistics counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-low
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  the instruction in ID reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_is_load  in  1  the instruction in EX is a load
- ex_redirect  in  1  branch taken, jump or mispredict resolved in EX
- ex_mdu_start  in  1  the instruction in EX is a multi-cycle MUL/DIV, first cycle
- mdu_done  in  1  one-cycle pulse: MDU result valid
- mem_busy  in  1  data memory not ready; the MEM stage must wait
- pc_hold  out  1  freeze the PC
- if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_hold  out  1 each  register keeps its value
- if_id_flush_n, id_ex_flush_n, ex_mem_flush_n  out  1 each  active-low: register loads NOP
- mem_timeout  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT
- stall_cycles, flush_events  out  CNT_W each  statistics counters (see Optional Feature)

Behaviour:
- Reset (rst=0 at posedge):
  - FSM returns to RUN; done_pending=0; wait_cnt=0; mem_timeout=0; counters=0.
  - Combinational outputs during reset: all holds 0, all flush_n 1.
- FSM states RUN, MDU_WAIT:
  - RUN -> MDU_WAIT: ex_mdu_start=1 and mdu_done=0 and freeze=0.
  - MDU_WAIT -> RUN: (mdu_done=1 or done_pending=1) and freeze=0.
- freeze = mem_busy.
  - mdu_done arriving while freeze=1 sets done_pending.
  - done_pending clears on the MDU_WAIT -> RUN transition.
- Define:
  - mdu_stall = (RUN and ex_mdu_start and not mdu_done) or (MDU_WAIT and not mdu_done and not done_pending).
  - load_use = ex_is_load and ex_rd!=0 and ((id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd)).
- Priority, highest first; outputs not listed are hold=0, flush_n=1:
  1. freeze: pc_hold and all four holds =1; no flushes.
  2. mdu_stall: pc_hold, if_id_hold, id_ex_hold =1; ex_mem_flush_n=0 (bubble into MEM); mem_wb flows.
  3. ex_redirect: if_id_flush_n=0 and id_ex_flush_n=0; pc not held (the PC loads the target).
  4. load_use: pc_hold=1, if_id_hold=1, id_ex_flush_n=0 (one bubble).
- Redirect overrides load_use: the ID instruction is wrong-path.
- ex_redirect during mdu_stall is ignored; the bench asserts it never occurs.
- A hold and the matching flush_n=0 are never asserted together.
- wait_cnt:
  - Increments while mem_busy=1, saturating at MEM_TIMEOUT.
  - Clears when mem_busy=0.
  - mem_timeout is set on the cycle wait_cnt reaches MEM_TIMEOUT-1 with mem_busy=1, and stays set until reset.
- Reset mid-MDU_WAIT returns to RUN with no residual stall on the next cycle.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - stall_cycles increments every cycle pc_hold=1.
  - flush_events increments every cycle any flush_n=0.
  - Both wrap at 2^CNT_W and clear on reset.
- When undefined: both outputs are constant 0 and no counter flops are built.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_hold=1, if_id_hold=1, id_ex_flush_n=0 for exactly 1 cycle. With ex_rd=0 instead -> no stall.
- Redirect plus load-use in the same cycle -> if_id_flush_n=0, id_ex_flush_n=0, pc_hold=0, if_id_hold=0.
- MDU: ex_mdu_start pulse, mdu_done 4 cycles later -> pc_hold/if_id_hold/id_ex_hold high for 4 cycles, ex_mem_flush_n=0 for 4 cycles, then RUN.
- mdu_done during mem_busy=1 (3 cycles) -> all holds high for the 3 cycles, done_pending=1, back to RUN on the first cycle mem_busy=0 with no further stall.
- mem_busy held for MEM_TIMEOUT=4 cycles -> mem_timeout rises at the end of the 4th cycle and stays 1 after mem_busy drops, until rst=0.
- With HAZARD_STATS_EN, the MDU case above -> stall_cycles=4, flush_events=4. Without the macro -> both read 0.
